// File: rtl/hold_capture_reader.sv
// rtl/hold_capture_reader.sv - hold register with a capture queue drained by a ready/valid reader
//
// Purpose:
//   Every cycle with a nonzero capture enable b loads a into the hold register y.
//   The same capture is also pushed into a DEPTH-entry FIFO. A reader drains that FIFO
//   with a valid/ready handshake. A capture that finds the queue full, with no pop in the
//   same cycle, is dropped and sets a sticky overflow flag.
//
// Ports:
//   clock    in   single clock, rising edge
//   reset    in   synchronous, active-high
//   a        in   [WIDTH] capture data
//   b        in   [WIDTH] capture enable (capture when b != 0)
//   y        out  [WIDTH] last captured a
//   rd_valid out  queue head valid (count != 0)
//   rd_ready in   reader accepts head
//   rd_data  out  [WIDTH] queue head, 0 when empty
//   count    out  [$clog2(DEPTH)+1] queue occupancy
//   overflow out  sticky dropped-capture flag

module hold_capture_reader #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  output logic [WIDTH-1:0]       y,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             ovf_q, ovf_d;

  logic cap;
  logic pop;
  logic full;
  logic push;

  assign cap  = (b != '0);
  assign pop  = rd_valid && rd_ready;
  assign full = (count_q == CW'(DEPTH));
  // A pop in the same cycle frees the slot the push needs, so a full queue still accepts.
  assign push = cap && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    y_d      = y_q;
    ovf_d    = ovf_q;

    if (cap) begin
      y_d = a;
    end
    if (cap && !push) begin
      ovf_d = 1'b1;
    end
    // Pointer width is exactly log2(DEPTH), so the increments wrap modulo DEPTH.
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      y_q      <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      y_q      <= y_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: entries are only visible through count, which reset clears.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= a;
    end
  end

  assign y        = y_q;
  assign count    = count_q;
  assign overflow = ovf_q;
  assign rd_valid = (count_q != '0);
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_hold_capture_reader.sv
// tb/tb_hold_capture_reader.sv - scoreboard testbench for hold_capture_reader

module tb_hold_capture_reader;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic                   clock;
  logic                   reset;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic [WIDTH-1:0]       y;
  logic                   rd_valid;
  logic                   rd_ready;
  logic [WIDTH-1:0]       rd_data;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;

  int tests_run;
  int tests_failed;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] y_m;
  logic             ovf_m;

  hold_capture_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .a        (a),
    .b        (b),
    .y        (y),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .count    (count),
    .overflow (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input int unsigned act, input int unsigned exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Called just after a falling edge; applies one cycle of stimulus and checks both sides of it.
  task automatic step(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic rdy);
    logic [WIDTH-1:0] head;
    a        = av;
    b        = bv;
    rd_ready = rdy;
    #1;
    check("rd_valid", int'(rd_valid), int'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("rd_data", int'(rd_data), int'(exp_q[0]));
      if (rdy) head = exp_q.pop_front();
    end else begin
      check("rd_data_empty", int'(rd_data), 0);
    end
    if (bv != 0) begin
      y_m = av;
      if (exp_q.size() < DEPTH) exp_q.push_back(av);
      else ovf_m = 1'b1;
    end
    @(posedge clock);
    @(negedge clock);
    check("y", int'(y), int'(y_m));
    check("count", int'(count), exp_q.size());
    check("overflow", int'(overflow), int'(ovf_m));
    check("count_bound", int'(count <= DEPTH), 1);
  endtask

  task automatic do_reset(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    reset    = 1'b1;
    a        = av;
    b        = bv;
    rd_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    y_m   = '0;
    ovf_m = 1'b0;
    check("rst_y", int'(y), 0);
    check("rst_count", int'(count), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_rd_valid", int'(rd_valid), 0);
    check("rst_rd_data", int'(rd_data), 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && exp_q.size() != 0; i++) step(8'd0, 8'd0, 1'b1);
    check("drained", exp_q.size(), 0);
    check("drained_valid", int'(rd_valid), 0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    y_m          = '0;
    ovf_m        = 1'b0;
    reset        = 1'b1;
    a            = '0;
    b            = '0;
    rd_ready     = 1'b0;
    @(negedge clock);
    do_reset(8'd0, 8'd0);

    // Hold behaviour with an always-ready reader
    step(8'd1, 8'd1, 1'b1);
    check("hold_y0", int'(y), 1);
    step(8'd3, 8'd0, 1'b1);
    check("hold_y1", int'(y), 1);
    step(8'd5, 8'd2, 1'b1);
    check("hold_y2", int'(y), 5);
    step(8'd7, 8'd0, 1'b1);
    check("hold_y3", int'(y), 5);
    step(8'd0, 8'd0, 1'b1);

    // Fill, then overflow from full
    do_reset(8'd0, 8'd0);
    for (int i = 0; i < 4; i++) step(8'(10 + i), 8'd1, 1'b0);
    check("fill_count", int'(count), 4);
    check("fill_ovf", int'(overflow), 0);
    check("fill_head", int'(rd_data), 10);
    step(8'd14, 8'd1, 1'b0);
    check("ovf_count", int'(count), 4);
    check("ovf_flag", int'(overflow), 1);
    check("ovf_y", int'(y), 14);
    drain();
    check("ovf_sticky", int'(overflow), 1);

    // Push and pop together while full
    do_reset(8'd0, 8'd0);
    for (int i = 0; i < 4; i++) step(8'(10 + i), 8'd1, 1'b0);
    step(8'd20, 8'd1, 1'b1);
    check("fpp_count", int'(count), 4);
    check("fpp_ovf", int'(overflow), 0);
    check("fpp_head", int'(rd_data), 11);
    drain();

    // Pointer wrap over ten push/pop pairs
    for (int i = 0; i < 10; i++) step(8'(i), 8'd1, 1'b1);
    drain();

    // Mixed random traffic against the scoreboard
    for (int i = 0; i < 60; i++)
      step(8'($urandom_range(1, 255)), 8'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    drain();

    // Reset in the middle of a stream, with a capture in the reset cycle
    do_reset(8'd0, 8'd0);
    for (int i = 0; i < 4; i++) step(8'(30 + i), 8'd1, 1'b0);
    step(8'd40, 8'd1, 1'b0);
    step(8'd0, 8'd0, 1'b1);
    check("mid_count", int'(count), 3);
    check("mid_ovf", int'(overflow), 1);
    do_reset(8'd9, 8'd1);
    step(8'd6, 8'd1, 1'b0);
    check("post_rst_valid", int'(rd_valid), 1);
    check("post_rst_data", int'(rd_data), 6);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
